// File: rtl/sig_buf_pkg.sv
// Shared constants for the signal display memory. The display reader imports
// the same package so both ends agree on trace placement and depth.
package sig_buf_pkg;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned WDATA_W = 32;
  localparam int unsigned DEPTH   = 640;
  localparam int unsigned PTR_W   = 10;

  localparam logic [ADDR_W-1:0] ECG_BASE  = 12'h801;
  localparam logic [ADDR_W-1:0] EMG_BASE  = 12'h559;
  localparam logic [DATA_W-1:0] CLAMP_MAX = 12'hEFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_ECG = 2'd1,
    WR_EMG = 2'd2
  } arb_state_e;

  // RAM address of a trace column; wraps naturally in 12 bits.
  function automatic logic [ADDR_W-1:0] trace_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [PTR_W-1:0]  ptr);
    return base + ADDR_W'(ptr);
  endfunction

endpackage

// File: rtl/sig_buffer_writer_if.sv
// Sample-stream handshakes plus the RAM write port of the signal writer.
// master = the writer (it masters the RAM port), slave = its environment.
interface sig_buffer_writer_if;
  import sig_buf_pkg::*;

  logic               ecg_valid;
  logic [DATA_W-1:0]  ecg_data;
  logic               ecg_ready;
  logic               emg_valid;
  logic [DATA_W-1:0]  emg_data;
  logic               emg_ready;
  logic               freeze;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [WDATA_W-1:0] mem_wdata;
  logic               ecg_wrap;
  logic               emg_wrap;

  modport master (
    input  ecg_valid, ecg_data, emg_valid, emg_data, freeze,
    output ecg_ready, emg_ready, mem_we, mem_addr, mem_wdata, ecg_wrap, emg_wrap
  );

  modport slave (
    output ecg_valid, ecg_data, emg_valid, emg_data, freeze,
    input  ecg_ready, emg_ready, mem_we, mem_addr, mem_wdata, ecg_wrap, emg_wrap
  );

endinterface

// File: rtl/sig_chan_ingest.sv
// One acquisition channel: decimates accepted samples, clamps the kept ones
// into a one-entry holding register and tracks the circular trace pointer.
module sig_chan_ingest
  import sig_buf_pkg::*;
#(
  parameter int unsigned       DECIM = 4,
  parameter logic [ADDR_W-1:0] BASE  = ECG_BASE
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              freeze_i,
  input  logic              grant_i,
  output logic              ready_o,
  output logic              pending_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] sample_o,
  output logic              at_last_o
);

  localparam int unsigned       DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DEC_W-1:0]  DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);

  logic              pend_q, pend_d;
  logic              ready_q, ready_d;
  logic [DEC_W-1:0]  dec_q, dec_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] hold_q;
  logic              accept;
  logic              load;

  // Saturate so the display row (bits [11:4]) never exceeds 239.
  function automatic logic [DATA_W-1:0] clamp(input logic [DATA_W-1:0] x);
    return (x > CLAMP_MAX) ? CLAMP_MAX : x;
  endfunction

  assign accept = valid_i && ready_q;

  // Next-state for pending flag, decimation counter and trace pointer.
  // Grant and accept never coincide: ready is low while a sample is pending.
  always_comb begin
    pend_d = pend_q;
    dec_d  = dec_q;
    ptr_d  = ptr_q;
    load   = 1'b0;
    if (grant_i) begin
      pend_d = 1'b0;
      ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    end
    if (accept && !freeze_i) begin
      dec_d = (dec_q == DEC_LAST) ? '0 : dec_q + DEC_W'(1);
      if (dec_q == '0) begin
        pend_d = 1'b1;
        load   = 1'b1;
      end
    end
    ready_d = !pend_d;
  end

  // Control state; ready comes up one cycle after reset releases.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
      dec_q   <= '0;
      ptr_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      ready_q <= ready_d;
      dec_q   <= dec_d;
      ptr_q   <= ptr_d;
    end
  end

  // Holding register; only read while pending, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (load) hold_q <= clamp(data_i);
  end

  assign ready_o   = ready_q;
  assign pending_o = pend_q;
  assign addr_o    = trace_addr(BASE, ptr_q);
  assign sample_o  = hold_q;
  assign at_last_o = (ptr_q == PTR_LAST);

endmodule

// File: rtl/sig_buffer_writer.sv
// Producer side of the signal display memory: two decimating channels feed a
// round-robin arbiter that issues at most one RAM write per cycle.
module sig_buffer_writer
  import sig_buf_pkg::*;
#(
  parameter int unsigned DECIM = 4
) (
  input logic               clock,
  input logic               reset,
  sig_buffer_writer_if.master bus
);

  arb_state_e         state_q, state_d;
  logic               last_emg_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WDATA_W-1:0] wdata_q, wdata_d;
  logic               ecg_wrap_q, ecg_wrap_d;
  logic               emg_wrap_q, emg_wrap_d;
  logic               grant_ecg, grant_emg;

  logic               ecg_pend, emg_pend;
  logic [ADDR_W-1:0]  ecg_addr, emg_addr;
  logic [DATA_W-1:0]  ecg_sample, emg_sample;
  logic               ecg_last, emg_last;

  sig_chan_ingest #(.DECIM(DECIM), .BASE(ECG_BASE)) u_ecg (
    .clk_i     (clock),
    .rst_ni    (reset),
    .valid_i   (bus.ecg_valid),
    .data_i    (bus.ecg_data),
    .freeze_i  (bus.freeze),
    .grant_i   (grant_ecg),
    .ready_o   (bus.ecg_ready),
    .pending_o (ecg_pend),
    .addr_o    (ecg_addr),
    .sample_o  (ecg_sample),
    .at_last_o (ecg_last)
  );

  sig_chan_ingest #(.DECIM(DECIM), .BASE(EMG_BASE)) u_emg (
    .clk_i     (clock),
    .rst_ni    (reset),
    .valid_i   (bus.emg_valid),
    .data_i    (bus.emg_data),
    .freeze_i  (bus.freeze),
    .grant_i   (grant_emg),
    .ready_o   (bus.emg_ready),
    .pending_o (emg_pend),
    .addr_o    (emg_addr),
    .sample_o  (emg_sample),
    .at_last_o (emg_last)
  );

  // Arbiter next state and the write-port values it will register.
  // A tie goes to the channel that was not granted last.
  always_comb begin
    state_d    = IDLE;
    grant_ecg  = 1'b0;
    grant_emg  = 1'b0;
    addr_d     = '0;
    wdata_d    = '0;
    ecg_wrap_d = 1'b0;
    emg_wrap_d = 1'b0;
    if (ecg_pend && emg_pend) state_d = last_emg_q ? WR_ECG : WR_EMG;
    else if (ecg_pend)        state_d = WR_ECG;
    else if (emg_pend)        state_d = WR_EMG;
    case (state_d)
      WR_ECG: begin
        grant_ecg  = 1'b1;
        addr_d     = ecg_addr;
        wdata_d    = {{(WDATA_W-DATA_W){1'b0}}, ecg_sample};
        ecg_wrap_d = ecg_last;
      end
      WR_EMG: begin
        grant_emg  = 1'b1;
        addr_d     = emg_addr;
        wdata_d    = {{(WDATA_W-DATA_W){1'b0}}, emg_sample};
        emg_wrap_d = emg_last;
      end
      default: ;
    endcase
  end

  // State register doubles as the output stage; reset favours ECG first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_emg_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      ecg_wrap_q <= 1'b0;
      emg_wrap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (state_d == WR_ECG)      last_emg_q <= 1'b0;
      else if (state_d == WR_EMG) last_emg_q <= 1'b1;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ecg_wrap_q <= ecg_wrap_d;
      emg_wrap_q <= emg_wrap_d;
    end
  end

  assign bus.mem_we    = (state_q != IDLE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.ecg_wrap  = ecg_wrap_q;
  assign bus.emg_wrap  = emg_wrap_q;

endmodule
